// File: rtl/nfa_match_reporter.sv
// Match reporter behind the NFA engines: turns the first rise of each engine
// match line in a packet into a {id, offset} record, plus one end-of-packet summary.
module nfa_match_reporter #(
    parameter int N_ENG     = 8,
    parameter int ID_W      = 3,
    parameter int OFF_W     = 16,
    parameter int MATCH_LAT = 2,
    parameter int DEPTH     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sod,
    input  logic             en,
    input  logic             eod,
    input  logic [N_ENG-1:0] match_in,
    output logic             rep_valid,
    input  logic             rep_ready,
    output logic             rep_eop,
    output logic [ID_W-1:0]  rep_id,
    output logic [OFF_W-1:0] rep_offset,
    output logic             err_trunc,
    output logic             busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = $clog2(MATCH_LAT + 2);
    localparam int CW = ID_W + 6;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

    state_t           state, state_next;
    logic [DW-1:0]    drain_cnt, drain_next;
    logic [OFF_W-1:0] byte_idx;
    logic [N_ENG-1:0] seen, pend, rise, grant, grant_clr;
    logic [OFF_W-1:0] off_cap [N_ENG];
    logic [ID_W-1:0]  match_cnt, cnt_next;
    logic [CW-1:0]    cnt_sum;
    logic             start, capture, can_push, pop;
    logic             push, push_eop, push_match;
    logic [ID_W-1:0]  push_id, grant_id;
    logic [OFF_W-1:0] push_off, grant_off, eop_off;

    logic             fifo_eop [DEPTH];
    logic [ID_W-1:0]  fifo_id  [DEPTH];
    logic [OFF_W-1:0] fifo_off [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      fill;
    logic             full;

    // byte_idx doubles as last_idx: it always holds the index of the last strobed byte
    assign start      = en && sod;
    assign capture    = (state == RUN || state == DRAIN) && !start;
    assign rise       = capture ? (match_in & ~seen) : '0;
    assign full       = (fill == (AW+1)'(DEPTH));
    assign pop        = rep_valid && rep_ready;
    assign can_push   = !full || rep_ready;
    assign eop_off    = (byte_idx == '1) ? byte_idx : byte_idx + 1'b1;

    assign rep_valid  = (fill != '0);
    assign rep_eop    = fifo_eop[rd_ptr];
    assign rep_id     = fifo_id[rd_ptr];
    assign rep_offset = fifo_off[rd_ptr];
    assign busy       = (state != IDLE) || rep_valid;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_off = '0;
        for (int i = N_ENG - 1; i >= 0; i--) begin
            if (pend[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_id  = ID_W'(i);
                grant_off = off_cap[i];
            end
        end
    end

    always_comb begin
        cnt_sum = CW'(match_cnt);
        for (int i = 0; i < N_ENG; i++) begin
            cnt_sum = cnt_sum + CW'(rise[i]);
        end
        cnt_next = (cnt_sum > CW'({ID_W{1'b1}})) ? '1 : cnt_sum[ID_W-1:0];
    end

    // A new sod aborts whatever packet is open, so it overrides every state.
    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        push       = 1'b0;
        push_eop   = 1'b0;
        push_match = 1'b0;
        push_id    = '0;
        push_off   = '0;
        if (start) begin
            state_next = eod ? DRAIN : RUN;
            drain_next = DW'(MATCH_LAT);
        end else begin
            case (state)
                IDLE: ;
                RUN: begin
                    if (en && eod) begin
                        state_next = DRAIN;
                        drain_next = DW'(MATCH_LAT);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) state_next = FLUSH;
                    else                 drain_next = drain_cnt - 1'b1;
                end
                FLUSH: begin
                    if (pend == '0 && can_push) begin
                        push       = 1'b1;
                        push_eop   = 1'b1;
                        push_id    = match_cnt;
                        push_off   = eop_off;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
            if (pend != '0 && can_push) begin
                push       = 1'b1;
                push_match = 1'b1;
                push_id    = grant_id;
                push_off   = grant_off;
            end
        end
    end

    assign grant_clr = push_match ? grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            byte_idx  <= '0;
            seen      <= '0;
            pend      <= '0;
            match_cnt <= '0;
            err_trunc <= 1'b0;
            for (int i = 0; i < N_ENG; i++) off_cap[i] <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            if (start) begin
                seen      <= '0;
                pend      <= '0;
                match_cnt <= '0;
                byte_idx  <= '0;
                if (state != IDLE) err_trunc <= 1'b1;
            end else begin
                seen      <= seen | rise;
                pend      <= (pend & ~grant_clr) | rise;
                match_cnt <= cnt_next;
                if (state == RUN && en && byte_idx != '1) byte_idx <= byte_idx + 1'b1;
            end
            for (int i = 0; i < N_ENG; i++) begin
                if (rise[i]) off_cap[i] <= byte_idx;
            end
        end
    end

    // Report FIFO; storage is cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_eop[i] <= 1'b0;
                fifo_id[i]  <= '0;
                fifo_off[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_eop[wr_ptr] <= push_eop;
                fifo_id[wr_ptr]  <= push_id;
                fifo_off[wr_ptr] <= push_off;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fill <= fill + 1'b1;
            else if (!push && pop) fill <= fill - 1'b1;
        end
    end
endmodule

// File: tb/tb_nfa_match_reporter.sv
// Self-checking bench for nfa_match_reporter: directed scenarios plus random
// packets scored against a per-packet model of first-rise offsets.
module tb_nfa_match_reporter;
    localparam int MATCH_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, sod, en, eod, rep_ready;
    logic [7:0]  match_in;
    logic        rep_valid, rep_eop, err_trunc, busy;
    logic [2:0]  rep_id;
    logic [15:0] rep_offset;

    typedef struct {
        logic        eop;
        logic [2:0]  id;
        logic [15:0] off;
        int          cyc;
    } rec_t;

    rec_t recs[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rand_ready = 1'b0;
    logic rdy = 1'b1;

    nfa_match_reporter dut (
        .clk(clk), .rst(rst), .sod(sod), .en(en), .eod(eod), .match_in(match_in),
        .rep_valid(rep_valid), .rep_ready(rep_ready), .rep_eop(rep_eop),
        .rep_id(rep_id), .rep_offset(rep_offset), .err_trunc(err_trunc), .busy(busy)
    );

    always #5 clk = ~clk;

    // One clock: drive at the falling edge, log any handshake, advance to the next falling edge.
    task automatic step(input logic s, input logic e, input logic d, input logic [7:0] m);
        rec_t r;
        sod = s; en = e; eod = d; match_in = m;
        rep_ready = rand_ready ? 1'($urandom_range(0, 1)) : rdy;
        if (rep_valid && rep_ready) begin
            r.eop = rep_eop; r.id = rep_id; r.off = rep_offset; r.cyc = cyc;
            recs.push_back(r);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic quiet(input int max, input logic [7:0] m, output bit tmo);
        tmo = 1'b1;
        for (int k = 0; k <= max; k++) begin
            if (!busy && !rep_valid) begin
                tmo = 1'b0;
                break;
            end
            if (k < max) step(1'b0, 1'b0, 1'b0, m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'hFF);
        rst = 1'b0;
        checks++;
        if ({rep_valid, rep_eop, rep_id, rep_offset, err_trunc, busy} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got v=%0b e=%0b id=%0d off=%0d t=%0b b=%0b want all 0",
                     rep_valid, rep_eop, rep_id, rep_offset, err_trunc, busy);
        end
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_en_ignored got busy=%0b want 0", busy);
        end
    endtask

    task automatic test_single_match();
        int base;
        bit tmo;
        recs.delete(); rdy = 1'b1; base = cyc;
        for (int c = 0; c < 10; c++) step(c == 0, 1'b1, c == 9, (c >= 6) ? 8'h08 : 8'h00);
        quiet(100, 8'h08, tmo);
        checks++;
        if (tmo) begin errors++; $display("[TB] FAIL single_quiet got busy=%0b want 0", busy); end
        checks++;
        if (recs.size() != 2) begin
            errors++;
            $display("[TB] FAIL single_count got %0d want 2", recs.size());
        end else begin
            checks++;
            if ({recs[0].eop, recs[0].id, recs[0].off} !== {1'b0, 3'd3, 16'd5}) begin
                errors++;
                $display("[TB] FAIL single_match got eop=%0b id=%0d off=%0d want 0/3/5",
                         recs[0].eop, recs[0].id, recs[0].off);
            end
            checks++;
            if ({recs[1].eop, recs[1].id, recs[1].off} !== {1'b1, 3'd1, 16'd10}) begin
                errors++;
                $display("[TB] FAIL single_eop got eop=%0b id=%0d off=%0d want 1/1/10",
                         recs[1].eop, recs[1].id, recs[1].off);
            end
            checks++;
            if (recs[0].cyc - base != 8) begin
                errors++;
                $display("[TB] FAIL single_latency got cycle %0d want 8", recs[0].cyc - base);
            end
        end
    endtask

    task automatic test_simultaneous();
        bit tmo;
        recs.delete(); rdy = 1'b1;
        for (int c = 0; c < 10; c++) step(c == 0, 1'b1, c == 9, (c >= 5) ? 8'h42 : 8'h00);
        quiet(100, 8'h42, tmo);
        checks++;
        if (tmo || recs.size() != 3) begin
            errors++;
            $display("[TB] FAIL simul_count got %0d records tmo=%0b want 3", recs.size(), tmo);
        end else begin
            checks++;
            if ({recs[0].eop, recs[0].id, recs[0].off, recs[1].eop, recs[1].id, recs[1].off}
                !== {1'b0, 3'd1, 16'd4, 1'b0, 3'd6, 16'd4}) begin
                errors++;
                $display("[TB] FAIL simul_order got id%0d@%0d id%0d@%0d want id1@4 id6@4",
                         recs[0].id, recs[0].off, recs[1].id, recs[1].off);
            end
            checks++;
            if (recs[1].cyc != recs[0].cyc + 1) begin
                errors++;
                $display("[TB] FAIL simul_back_to_back got gap %0d want 1", recs[1].cyc - recs[0].cyc);
            end
            checks++;
            if ({recs[2].eop, recs[2].id, recs[2].off} !== {1'b1, 3'd2, 16'd10}) begin
                errors++;
                $display("[TB] FAIL simul_eop got eop=%0b id=%0d off=%0d want 1/2/10",
                         recs[2].eop, recs[2].id, recs[2].off);
            end
        end
    endtask

    // Engine k rises the cycle after byte k, so its offset is k.
    task automatic test_backpressure();
        logic [7:0] m;
        bit tmo;
        recs.delete(); rdy = 1'b0; m = '0;
        for (int c = 0; c < 12; c++) begin
            if (c >= 1 && c <= 8) m[c-1] = 1'b1;
            step(c == 0, 1'b1, c == 11, m);
        end
        for (int c = 0; c < 15; c++) step(1'b0, 1'b0, 1'b0, m);
        checks++;
        if (rep_valid !== 1'b1 || busy !== 1'b1 || recs.size() != 0) begin
            errors++;
            $display("[TB] FAIL bp_hold got valid=%0b busy=%0b popped=%0d want 1/1/0",
                     rep_valid, busy, recs.size());
        end
        checks++;
        if ({rep_eop, rep_id, rep_offset} !== {1'b0, 3'd0, 16'd0}) begin
            errors++;
            $display("[TB] FAIL bp_head got eop=%0b id=%0d off=%0d want 0/0/0", rep_eop, rep_id, rep_offset);
        end
        rdy = 1'b1;
        quiet(100, m, tmo);
        checks++;
        if (tmo || recs.size() != 9) begin
            errors++;
            $display("[TB] FAIL bp_count got %0d records tmo=%0b want 9", recs.size(), tmo);
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if ({recs[k].eop, recs[k].id, recs[k].off} !== {1'b0, 3'(k), 16'(k)}) begin
                    errors++;
                    $display("[TB] FAIL bp_rec%0d got eop=%0b id=%0d off=%0d want 0/%0d/%0d",
                             k, recs[k].eop, recs[k].id, recs[k].off, k, k);
                end
            end
            checks++;
            if ({recs[8].eop, recs[8].id, recs[8].off} !== {1'b1, 3'd7, 16'd12}) begin
                errors++;
                $display("[TB] FAIL bp_eop got eop=%0b id=%0d off=%0d want 1/7/12",
                         recs[8].eop, recs[8].id, recs[8].off);
            end
        end
    endtask

    task automatic test_sticky();
        logic [7:0] m;
        bit tmo;
        recs.delete(); rdy = 1'b1;
        for (int c = 0; c < 30; c++) begin
            m = '0;
            m[2] = (c >= 3 && c <= 22) || (c >= 25 && c <= 27) || (c == 29);
            step(c == 0, 1'b1, c == 29, m);
        end
        quiet(100, 8'h04, tmo);
        checks++;
        if (tmo || recs.size() != 2) begin
            errors++;
            $display("[TB] FAIL sticky_count got %0d records tmo=%0b want 2", recs.size(), tmo);
        end else begin
            checks++;
            if ({recs[0].eop, recs[0].id, recs[0].off, recs[1].eop, recs[1].id, recs[1].off}
                !== {1'b0, 3'd2, 16'd2, 1'b1, 3'd1, 16'd30}) begin
                errors++;
                $display("[TB] FAIL sticky_recs got id%0d@%0d eop id%0d@%0d want id2@2 eop 1@30",
                         recs[0].id, recs[0].off, recs[1].id, recs[1].off);
            end
        end
    endtask

    task automatic test_one_byte();
        bit tmo;
        recs.delete(); rdy = 1'b1;
        step(1'b1, 1'b1, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h10);
        quiet(100, 8'h10, tmo);
        checks++;
        if (tmo || recs.size() != 2) begin
            errors++;
            $display("[TB] FAIL one_byte_count got %0d records tmo=%0b want 2", recs.size(), tmo);
        end else begin
            checks++;
            if ({recs[0].eop, recs[0].id, recs[0].off, recs[1].eop, recs[1].id, recs[1].off}
                !== {1'b0, 3'd4, 16'd0, 1'b1, 3'd1, 16'd1}) begin
                errors++;
                $display("[TB] FAIL one_byte_recs got id%0d@%0d eop id%0d@%0d want id4@0 eop 1@1",
                         recs[0].id, recs[0].off, recs[1].id, recs[1].off);
            end
        end
    endtask

    // Engine 5 rises in the drain window one cycle before the next sod, so it is still pending when aborted.
    task automatic test_truncation();
        bit tmo;
        recs.delete(); rdy = 1'b1;
        for (int c = 0; c < 6; c++) step(c == 0, 1'b1, c == 5, (c >= 3) ? 8'h01 : 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h21);
        for (int c = 0; c < 8; c++) step(c == 0, 1'b1, c == 7, (c >= 4) ? 8'h02 : 8'h00);
        quiet(100, 8'h02, tmo);
        checks++;
        if (err_trunc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL trunc_flag got %0b want 1", err_trunc);
        end
        checks++;
        if (tmo || recs.size() != 3) begin
            errors++;
            $display("[TB] FAIL trunc_count got %0d records tmo=%0b want 3", recs.size(), tmo);
        end else begin
            checks++;
            if ({recs[0].eop, recs[0].id, recs[0].off, recs[1].eop, recs[1].id, recs[1].off,
                 recs[2].eop, recs[2].id, recs[2].off}
                !== {1'b0, 3'd0, 16'd2, 1'b0, 3'd1, 16'd3, 1'b1, 3'd1, 16'd8}) begin
                errors++;
                $display("[TB] FAIL trunc_recs got id%0d@%0d id%0d@%0d eop%0b %0d@%0d want id0@2 id1@3 eop1 1@8",
                         recs[0].id, recs[0].off, recs[1].id, recs[1].off,
                         recs[2].eop, recs[2].id, recs[2].off);
            end
        end
    endtask

    task automatic test_reset_flush();
        logic [7:0] m;
        recs.delete(); rdy = 1'b0; m = '0;
        for (int c = 0; c < 10; c++) begin
            if (c >= 1 && c <= 8) m[c-1] = 1'b1;
            step(c == 0, 1'b1, c == 9, m);
        end
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 1'b0, m);
        checks++;
        if (busy !== 1'b1 || rep_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_stall got busy=%0b valid=%0b want 1/1", busy, rep_valid);
        end
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, m);
        rst = 1'b0;
        checks++;
        if ({rep_valid, rep_eop, rep_id, rep_offset, err_trunc, busy} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL flush_reset got v=%0b e=%0b id=%0d off=%0d t=%0b b=%0b want all 0",
                     rep_valid, rep_eop, rep_id, rep_offset, err_trunc, busy);
        end
        rdy = 1'b1;
        step(1'b0, 1'b0, 1'b0, m);
        checks++;
        if (rep_valid !== 1'b0 || busy !== 1'b0 || recs.size() != 0) begin
            errors++;
            $display("[TB] FAIL flush_empty got valid=%0b busy=%0b popped=%0d want 0/0/0",
                     rep_valid, busy, recs.size());
        end
    endtask

    // Model: an engine's offset is the number of bytes strobed before its first rise, minus one.
    task automatic test_random();
        int   len, tot, nmatch, ones, cnt;
        int   rc [8];
        int   eoff [8];
        bit   got [8];
        bit   en_q[$];
        bit   b, tmo;
        logic [7:0] m;
        rec_t r;
        rand_ready = 1'b1;
        for (int p = 0; p < 25; p++) begin
            en_q.delete();
            len = $urandom_range(1, 20);
            en_q.push_back(1'b1);
            ones = 1;
            while (ones < len) begin
                b = ($urandom_range(0, 3) != 0);
                en_q.push_back(b);
                if (b) ones++;
            end
            tot = en_q.size();
            nmatch = 0;
            for (int i = 0; i < 8; i++) begin
                got[i] = 1'b0;
                eoff[i] = 0;
                rc[i] = -1;
                if ($urandom_range(0, 1) == 1) begin
                    rc[i] = $urandom_range(1, tot - 1 + MATCH_LAT);
                    cnt = 0;
                    for (int c = 0; c < rc[i]; c++) if (c < tot && en_q[c]) cnt++;
                    eoff[i] = cnt - 1;
                    nmatch++;
                end
            end
            recs.delete();
            m = '0;
            for (int c = 0; c < tot + MATCH_LAT; c++) begin
                for (int i = 0; i < 8; i++) begin
                    if (rc[i] >= 0 && c >= rc[i]) m[i] = (c == rc[i]) ? 1'b1 : 1'($urandom_range(0, 1));
                    else m[i] = 1'b0;
                end
                step(c == 0, (c < tot) ? en_q[c] : 1'b0, c == tot - 1, m);
            end
            quiet(300, m, tmo);
            checks++;
            if (tmo || recs.size() != nmatch + 1) begin
                errors++;
                $display("[TB] FAIL rand_count pkt %0d got %0d records tmo=%0b want %0d",
                         p, recs.size(), tmo, nmatch + 1);
            end else begin
                for (int k = 0; k < nmatch; k++) begin
                    r = recs[k];
                    checks++;
                    if (r.eop !== 1'b0 || rc[r.id] < 0 || got[r.id] || r.off !== 16'(eoff[r.id])) begin
                        errors++;
                        $display("[TB] FAIL rand_match pkt %0d got eop=%0b id=%0d off=%0d dup=%0b want off=%0d expected=%0b",
                                 p, r.eop, r.id, r.off, got[r.id], eoff[r.id], rc[r.id] >= 0);
                    end
                    got[r.id] = 1'b1;
                end
                r = recs[nmatch];
                checks++;
                if ({r.eop, r.id, r.off} !== {1'b1, 3'((nmatch > 7) ? 7 : nmatch), 16'(len)}) begin
                    errors++;
                    $display("[TB] FAIL rand_eop pkt %0d got eop=%0b id=%0d off=%0d want 1/%0d/%0d",
                             p, r.eop, r.id, r.off, (nmatch > 7) ? 7 : nmatch, len);
                end
            end
        end
        rand_ready = 1'b0;
        checks++;
        if (err_trunc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_no_trunc got %0b want 0", err_trunc);
        end
    endtask

    initial begin
        rst = 1'b1; sod = 1'b0; en = 1'b0; eod = 1'b0; match_in = '0; rep_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_match();
        test_simultaneous();
        test_backpressure();
        test_sticky();
        test_one_byte();
        test_truncation();
        test_reset_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
